sram_bank_ctrl: RTL and testbench

//  Parametrised successor to the single-macro SoC data RAM hookup. It sits between the
//  soc_core SRAM port and NUM_BANKS synchronous RAM macros.

---
 rtl/sram_bank_pkg.sv | 21 ++
 rtl/sram_init_seq.sv | 69 ++++++
 rtl/sram_bank_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_bank_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_pkg.sv
// Shared types and sizing helpers for the banked SRAM controller.
// Bank-select width is never below one bit, so a single-bank build still has a range check.
package sram_bank_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int LANE_BITS = 8;

  function automatic int bank_sel_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int lane_cnt(input int dw);
    return dw / LANE_BITS;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Power-up / on-demand zeroise sequencer: walks every word address once while the
// controller holds off the master, then reports completion.
module sram_init_seq
  import sram_bank_pkg::*;
#(
  parameter int BANK_AW    = 10,
  parameter int INIT_CLEAR = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_req,
  output logic               clearing,
  output logic [BANK_AW-1:0] clr_addr,
  output logic               init_done,
  output logic [1:0]         state_dbg
);

  state_e             state_q, state_d;
  logic [BANK_AW-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      RST: begin
        cnt_d = '0;
        if (INIT_CLEAR != 0) begin
          state_d = CLEAR;
        end else begin
          state_d = READY;
          done_d  = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = READY;
          done_d  = 1'b1;
        end
      end
      READY: begin
        // Counter parked at zero so every re-run starts from word 0.
        cnt_d = '0;
        if (init_req) state_d = CLEAR;
      end
      default: state_d = RST;
    endcase
  end

  assign clearing  = (state_q == CLEAR);
  assign clr_addr  = cnt_q;
  assign init_done = done_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/sram_bank_ctrl.sv
// Banked SRAM front end: bank decode, registered read-data mux, zeroise control
// and a sticky out-of-range error flag.
module sram_bank_ctrl
  import sram_bank_pkg::*;
#(
  parameter int NUM_BANKS  = 3,
  parameter int BANK_AW    = 10,
  parameter int DW         = 32,
  parameter int INIT_CLEAR = 1,
  localparam int BSW = bank_sel_w(NUM_BANKS),
  localparam int NL  = lane_cnt(DW)
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    cs,
  input  logic [NL-1:0]           wen,
  input  logic [BSW+BANK_AW-1:0]  addr,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           rdata,
  output logic                    ready,
  input  logic                    init_req,
  output logic                    init_done,
  output logic                    err,
  input  logic                    err_clr,
  output logic [NUM_BANKS-1:0]    bank_en,
  output logic [NL-1:0]           bank_we,
  output logic [BANK_AW-1:0]      bank_a,
  output logic [DW-1:0]           bank_di,
  input  logic [NUM_BANKS*DW-1:0] bank_do
);

  logic               clearing;
  logic [BANK_AW-1:0] clr_addr;
  logic [1:0]         seq_state;

  sram_init_seq #(
    .BANK_AW   (BANK_AW),
    .INIT_CLEAR(INIT_CLEAR)
  ) u_init_seq (
    .clk      (HCLK),
    .rst      (HRESET),
    .init_req (init_req),
    .clearing (clearing),
    .clr_addr (clr_addr),
    .init_done(init_done),
    .state_dbg(seq_state)
  );

  // Handshake: a request is taken on any clock edge where cs and ready are both high;
  // there is no back-pressure beyond ready, and a read's data appears the next cycle.
  logic [BSW-1:0] bank_idx;
  logic           in_range;
  logic           accept;
  logic           rd_acc;
  logic           bad_acc;

  assign ready    = (state_e'(seq_state) == READY);
  assign bank_idx = addr[BSW+BANK_AW-1:BANK_AW];
  assign in_range = (int'(bank_idx) < NUM_BANKS);
  assign accept   = ready & cs;
  assign rd_acc   = accept & ~(|wen);
  assign bad_acc  = accept & ~in_range;

  always_comb begin
    bank_en = '0;
    bank_we = '0;
    bank_a  = '0;
    bank_di = '0;
    if (clearing) begin
      bank_en = '1;
      bank_we = '1;
      bank_a  = clr_addr;
    end else if (ready) begin
      // Out-of-range indices match no bank, which also drops stray writes.
      for (int k = 0; k < NUM_BANKS; k++) begin
        bank_en[k] = cs & (bank_idx == BSW'(k));
      end
      bank_we = wen;
      bank_a  = addr[BANK_AW-1:0];
      bank_di = wdata;
    end
  end

  logic [BSW-1:0] sel_q, sel_d;
  logic           rd_pend_q, rd_pend_d;
  logic           rd_ok_q, rd_ok_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rd_word;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_ok_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      rd_pend_q <= rd_pend_d;
      rd_ok_q   <= rd_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (sel_q == BSW'(k)) rd_word = bank_do[k*DW +: DW];
    end
  end

  always_comb begin
    sel_d     = rd_acc ? bank_idx : sel_q;
    rd_ok_d   = rd_acc ? in_range : rd_ok_q;
    rd_pend_d = rd_acc;
    // The macro output is live only in the cycle after the read; capture it to hold.
    rdata     = rd_pend_q ? (rd_ok_q ? rd_word : '0) : rdata_q;
    rdata_d   = rdata;
    err_d     = err_q;
    if (err_clr) err_d = 1'b0;
    if (bad_acc) err_d = 1'b1;
  end

  assign err = err_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl with three behavioural 16x32 synchronous RAM macros.
module tb_sram_bank_ctrl;

  localparam int NB  = 3;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int NL  = 4;
  localparam int BSW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cs, init_req, err_clr;
  logic [NL-1:0]     wen;
  logic [BSW+AW-1:0] addr;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;
  logic              ready, init_done, err;
  logic [NB-1:0]     bank_en;
  logic [NL-1:0]     bank_we;
  logic [AW-1:0]     bank_a;
  logic [DW-1:0]     bank_di;
  logic [NB*DW-1:0]  bank_do;

  sram_bank_ctrl #(
    .NUM_BANKS (NB),
    .BANK_AW   (AW),
    .DW        (DW),
    .INIT_CLEAR(1)
  ) dut (
    .HCLK     (clk),
    .HRESET   (rst),
    .cs       (cs),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .init_req (init_req),
    .init_done(init_done),
    .err      (err),
    .err_clr  (err_clr),
    .bank_en  (bank_en),
    .bank_we  (bank_we),
    .bank_a   (bank_a),
    .bank_di  (bank_di),
    .bank_do  (bank_do)
  );

  // RAM macro models, preloaded with garbage so zeroise is observable
  logic [DW-1:0] mem  [NB][16];
  logic [DW-1:0] dout [NB];

  initial begin
    for (int k = 0; k < NB; k++) begin
      dout[k] = '0;
      for (int w = 0; w < 16; w++) mem[k][w] = $urandom;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (bank_en[k]) begin
        if (|bank_we) begin
          for (int b = 0; b < NL; b++) begin
            if (bank_we[b]) mem[k][bank_a][b*8 +: 8] <= bank_di[b*8 +: 8];
          end
        end else begin
          dout[k] <= mem[k][bank_a];
        end
      end
    end
  end

  assign bank_do = {dout[2], dout[1], dout[0]};

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic c, input logic [NL-1:0] w, input logic [BSW+AW-1:0] a,
                       input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    cs    = c;
    wen   = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic expect_clear(input int first, input logic done);
    for (int i = first; i < 16; i++) begin
      @(negedge clk);
      check_eq("clear_vec", {19'd0, ready, init_done, bank_en, bank_we, bank_a},
               {19'd0, 1'b0, done, 3'b111, 4'hF, 4'(i)});
      check_eq("clear_di", bank_di, 32'd0);
    end
  endtask

  task automatic read_three(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [5:0]  a [3];
    logic [31:0] e [3];
    a = '{a0, a1, a2};
    e = '{e0, e1, e2};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, a[i], 32'd0);
      exp_q.push_back(e[i]);
      @(negedge clk);
      if (i > 0) check_eq("b2b_rdata", rdata, exp_q.pop_front());
    end
    drive(1'b0, 4'h0, 6'h00, 32'd0);
    @(negedge clk);
    check_eq("b2b_rdata", rdata, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d", n_total);
    $fatal(1, "bench did not finish");
  end

  initial begin
    cs = 1'b0; wen = '0; addr = '0; wdata = '0; init_req = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctl", {20'd0, ready, init_done, err, bank_en, bank_we, bank_a}, 32'd0);
    check_eq("reset_rdata", rdata, 32'd0);
    check_eq("reset_di", bank_di, 32'd0);

    // 1. power-up zeroise, then every word reads zero
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    expect_clear(0, 1'b0);
    @(negedge clk);
    check_eq("ready_after_clear", {30'd0, ready, init_done}, 32'd3);
    for (int a = 0; a < 48; a++) begin
      drive(1'b1, 4'h0, 6'(a), 32'd0);
      @(negedge clk);
      if (a > 0) check_eq("zero_rd", rdata, 32'd0);
    end
    drive(1'b0, 4'h0, 6'h00, 32'd0);
    @(negedge clk);
    check_eq("zero_rd", rdata, 32'd0);

    // 2. full write then read at 0x15
    drive(1'b1, 4'hF, 6'h15, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("wr_decode", {21'd0, bank_en, bank_we, bank_a}, {21'd0, 3'b010, 4'hF, 4'd5});
    check_eq("wr_di", bank_di, 32'hDEADBEEF);
    drive(1'b1, 4'h0, 6'h15, 32'd0);
    @(negedge clk);
    check_eq("rd_decode", {21'd0, bank_en, bank_we, bank_a}, {21'd0, 3'b010, 4'h0, 4'd5});
    check_eq("wr_keeps_rdata", rdata, 32'd0);
    drive(1'b0, 4'h0, 6'h00, 32'd0);
    @(negedge clk);
    check_eq("rd_data", rdata, 32'hDEADBEEF);

    // 3. byte-lane write, read straight after
    drive(1'b1, 4'b0100, 6'h15, 32'h00AA0000);
    drive(1'b1, 4'h0, 6'h15, 32'd0);
    drive(1'b0, 4'h0, 6'h00, 32'd0);
    @(negedge clk);
    check_eq("byte_wr", rdata, 32'hDEAABEEF);

    // 4. out-of-range access and sticky error
    drive(1'b1, 4'h0, 6'h30, 32'd0);
    @(negedge clk);
    check_eq("oor_en", {29'd0, bank_en}, 32'd0);
    check_eq("err_pre", {31'd0, err}, 32'd0);
    drive(1'b0, 4'h0, 6'h00, 32'd0);
    @(negedge clk);
    check_eq("oor_rdata", rdata, 32'd0);
    check_eq("err_set", {31'd0, err}, 32'd1);
    drive(1'b0, 4'h0, 6'h00, 32'd0);
    @(negedge clk);
    check_eq("err_sticky", {31'd0, err}, 32'd1);
    drive(1'b0, 4'h0, 6'h00, 32'd0); err_clr = 1'b1;
    drive(1'b0, 4'h0, 6'h00, 32'd0); err_clr = 1'b0;
    @(negedge clk);
    check_eq("err_clr", {31'd0, err}, 32'd0);
    drive(1'b1, 4'h0, 6'h30, 32'd0); err_clr = 1'b1;
    drive(1'b0, 4'h0, 6'h00, 32'd0); err_clr = 1'b0;
    @(negedge clk);
    check_eq("err_set_wins", {31'd0, err}, 32'd1);
    drive(1'b0, 4'h0, 6'h00, 32'd0); err_clr = 1'b1;
    drive(1'b0, 4'h0, 6'h00, 32'd0); err_clr = 1'b0;
    @(negedge clk);
    check_eq("err_clr2", {31'd0, err}, 32'd0);

    // 5. back-to-back reads across banks
    drive(1'b1, 4'hF, 6'h05, 32'd1);
    drive(1'b1, 4'hF, 6'h15, 32'd2);
    drive(1'b1, 4'hF, 6'h25, 32'd3);
    read_three(6'h05, 6'h15, 6'h25, 32'd1, 32'd2, 32'd3);
    drive(1'b0, 4'h0, 6'h00, 32'd0);
    @(negedge clk);
    check_eq("rd_hold", rdata, 32'd3);

    // 6. re-zeroise on request; a read on the request cycle still lands
    drive(1'b1, 4'h0, 6'h15, 32'd0); init_req = 1'b1;
    @(negedge clk);
    check_eq("init_req_accept", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    init_req = 1'b0; cs = 1'b1; wen = 4'h0; addr = 6'h30; wdata = 32'h12345678;
    expect_clear(0, 1'b1);
    cs = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    check_eq("ready_after_reinit", {30'd0, ready, init_done}, 32'd3);
    check_eq("rdata_after_init", rdata, 32'd2);
    check_eq("cs_ignored_in_clear", {31'd0, err}, 32'd0);
    read_three(6'h05, 6'h15, 6'h25, 32'd0, 32'd0, 32'd0);

    // HRESET part-way through a clear pass
    drive(1'b0, 4'h0, 6'h00, 32'd0); init_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("partial_clear_a", {28'd0, bank_a}, 32'(i));
    end
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mid_clear", {21'd0, ready, init_done, bank_en, bank_a}, 32'd0);
    check_eq("rst_mid_rdata", rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    expect_clear(0, 1'b0);
    @(negedge clk);
    check_eq("ready_after_rst", {30'd0, ready, init_done}, 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
